isq_alloc: RTL and testbench
============================

# isq_alloc

Parametrised issue queue: successor to the fixed-slot issue queue. It allocates up to INST_PORT dispatched instructions per cycle into free entries, tracks a per-entry valid bit and wait bit, and accepts wakeups from the scoreboard. Each cycle it selects up to ISSUE_PORT ready entries, lowest index first, and registers them onto the issue bus. It sits between rename/dispatch and the functional-unit issue stage, and supports a full-queue flush on branch mispredict.

## Interface
Parameters:
- ISQ_DEPTH, 64: number of entries.
- ISQ_IDX_BITS_NUM, 6: entry index width; must equal clog2(ISQ_DEPTH).
- INST_PORT, 4: dispatch ports per cycle.
- ISSUE_PORT, 2: issue ports per cycle.
- INST_WIDTH, 56: payload width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- disp_en  in  1  dispatch request for this cycle.
- inst_val  in  INST_PORT  per-port instruction valid; port 0 is oldest.
- inst_wat  in  INST_PORT  per-port initial wait bit; 1 = operands not ready.
- inst_in_flat  in  INST_WIDTH*INST_PORT  payloads; port k occupies bits [INST_WIDTH*(k+1)-1 : INST_WIDTH*k].
- clr_inst_wat  in  ISQ_DEPTH  wakeup; bit i clears the wait bit of entry i.
- fls  in  1  flush all entries.
- isq_rdy  out  1  queue can accept a full dispatch group this cycle.
- isq_cnt  out  ISQ_IDX_BITS_NUM+1  occupied-entry count.
- iss_val  out  ISSUE_PORT  issue slot valid.
- iss_idx_flat  out  ISQ_IDX_BITS_NUM*ISSUE_PORT  entry index of each issued instruction.
- iss_inst_flat  out  INST_WIDTH*ISSUE_PORT  issued payloads.

## Operation
- Entry state: val, wat, payload. Ready = val & ~wat.
- isq_rdy = (ISQ_DEPTH − isq_cnt) >= INST_PORT. It is computed from registered state only; an issue in the same cycle earns no credit.
- Dispatch accept = disp_en & isq_rdy & ~fls. When disp_en is high and isq_rdy is low, the entire group is dropped; the upstream stage must hold the group.
- Allocation: the k-th valid input port, counting only ports with inst_val set, goes to the k-th lowest-indexed free entry (val=0). Ports with inst_val=0 consume no entry.
- Allocated entry: val←1, wat←inst_wat[k], payload←inst_in[k].
- Select: the ISSUE_PORT lowest-indexed ready entries. Issue slot 0 takes the lowest index. Selected entries have val←0 at the edge.
- Wakeup: clr_inst_wat[i] clears wat[i] at the edge. It is ignored for an entry that is invalid or being allocated in that cycle.
- Count: isq_cnt_next = isq_cnt + allocated − issued. It never exceeds ISQ_DEPTH.
- Flush has priority over everything else:
  - all val←0, isq_cnt←0;
  - iss_val←0 at the same edge;
  - dispatch, select and wakeup in that cycle are discarded.

## Timing
- Reset values: all val=0, all wat=0, payloads 0, isq_cnt=0, iss_val=0, iss_idx_flat=0, iss_inst_flat=0. Consequently isq_rdy=1 out of reset.
- Dispatch on edge E: the entry is visible from E. If wat=0, the instruction is selected combinationally during the cycle after E and appears on iss_* after edge E+1. Minimum dispatch-to-issue latency is 2 cycles.
- A wakeup sampled at edge E makes the entry eligible for selection after E; it issues on iss_* after E+1.
- iss_* outputs are registered and valid for exactly one cycle per issue; there is no backpressure on the issue side.
- A freed entry can be reallocated by a dispatch in the cycle after it issues, not in the same cycle.
- Reset asserted mid-operation returns every register to its reset value immediately (asynchronous); no partial state survives.

## Structure
- Shared package isq_pkg holds:
  - entry field offsets (VAL bit, WAT bit, payload LSB);
  - the issue-record width ISQ_IDX_BITS_NUM+INST_WIDTH;
  - a clog2 function for deriving index widths.
- Sub-module isq_entry (one per entry): val/wat/payload registers with alloc, issue-clear, wakeup and flush controls. isq_alloc contains the free-slot allocator, the multi-grant priority select, the counter and the issue registers.

## Test plan
- Reset, then dispatch 4 valid ports with wat=0 and payloads 0xA..0xD → entries 0-3 filled, isq_cnt=4. iss_val=2'b11 with idx 0,1 two cycles later, then idx 2,3 one cycle after that; isq_cnt returns to 0.
- Dispatch with inst_val=4'b1010 → ports 1 and 3 land in entries 0 and 1 respectively; isq_cnt=2.
- Fill to 61 entries, all wat=1 → isq_rdy=0. A dispatch request is dropped and isq_cnt stays 61. Wake entry 5 → it issues, isq_cnt=60, isq_rdy=1.
- Entries 3 and 7 have wat=1 and entry 9 is ready → entry 9 issues first. Pulse clr_inst_wat[7] → entry 7 issues the next cycle on slot 0.
- Assert fls in the same cycle as a dispatch, a wakeup and a pending select → next cycle isq_cnt=0, iss_val=0, and no entry is valid.
- Assert rst_n low mid-stream with 20 entries occupied → all outputs read their reset values while rst_n is low, with no clock edge required.

Source files
------------

// File: rtl/isq_pkg.sv
// Shared definitions for the issue queue: entry field layout, issue-record
// width and a clog2 helper used to derive index widths.
package isq_pkg;

  localparam int ENT_VAL_BIT = 0;
  localparam int ENT_WAT_BIT = 1;
  localparam int ENT_PLD_LSB = 2;

  function automatic int isq_clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

  function automatic int isq_rec_width(input int idx_bits, input int inst_width);
    return idx_bits + inst_width;
  endfunction

endpackage

// File: rtl/isq_entry.sv
// One issue-queue slot: valid, wait and payload registers. Flush beats
// allocation, and allocation beats issue-clear and wakeup.
module isq_entry
  import isq_pkg::*;
#(
  parameter int INST_WIDTH = 56
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              fls,
  input  logic                              alloc,
  input  logic                              alloc_wat,
  input  logic [INST_WIDTH-1:0]             alloc_inst,
  input  logic                              iss_clr,
  input  logic                              wake,
  output logic [ENT_PLD_LSB+INST_WIDTH-1:0] ent
);

  logic                  val_reg;
  logic                  wat_reg;
  logic [INST_WIDTH-1:0] inst_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_reg  <= 1'b0;
      wat_reg  <= 1'b0;
      inst_reg <= '0;
    end else if (fls) begin
      val_reg <= 1'b0;
    end else if (alloc) begin
      val_reg  <= 1'b1;
      wat_reg  <= alloc_wat;
      inst_reg <= alloc_inst;
    end else begin
      if (iss_clr) val_reg <= 1'b0;
      // A wakeup aimed at an empty slot must not leak into its next occupant.
      if (wake && val_reg) wat_reg <= 1'b0;
    end
  end

  always_comb begin
    ent                              = '0;
    ent[ENT_VAL_BIT]                 = val_reg;
    ent[ENT_WAT_BIT]                 = wat_reg;
    ent[ENT_PLD_LSB +: INST_WIDTH]   = inst_reg;
  end

endmodule

// File: rtl/isq_alloc.sv
// Issue queue: allocates dispatch groups into the lowest free slots, selects
// the lowest-indexed ready slots each cycle and registers them onto the issue bus.
module isq_alloc
  import isq_pkg::*;
#(
  parameter int ISQ_DEPTH        = 64,
  parameter int ISQ_IDX_BITS_NUM = 6,
  parameter int INST_PORT        = 4,
  parameter int ISSUE_PORT       = 2,
  parameter int INST_WIDTH       = 56
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   disp_en,
  input  logic [INST_PORT-1:0]                   inst_val,
  input  logic [INST_PORT-1:0]                   inst_wat,
  input  logic [INST_WIDTH*INST_PORT-1:0]        inst_in_flat,
  input  logic [ISQ_DEPTH-1:0]                   clr_inst_wat,
  input  logic                                   fls,
  output logic                                   isq_rdy,
  output logic [ISQ_IDX_BITS_NUM:0]              isq_cnt,
  output logic [ISSUE_PORT-1:0]                  iss_val,
  output logic [ISQ_IDX_BITS_NUM*ISSUE_PORT-1:0] iss_idx_flat,
  output logic [INST_WIDTH*ISSUE_PORT-1:0]       iss_inst_flat
);

  localparam int IDX_W = isq_clog2(ISQ_DEPTH);
  localparam int CNT_W = ISQ_IDX_BITS_NUM + 1;
  localparam int ENT_W = ENT_PLD_LSB + INST_WIDTH;
  localparam int REC_W = isq_rec_width(ISQ_IDX_BITS_NUM, INST_WIDTH);

  logic [ISQ_DEPTH-1:0]  val_vec;
  logic [ISQ_DEPTH-1:0]  wat_vec;
  logic [ISQ_DEPTH-1:0]  rdy_vec;
  logic [INST_WIDTH-1:0] pld_arr [ISQ_DEPTH];

  logic [ISQ_DEPTH-1:0]  alloc_vec;
  logic [ISQ_DEPTH-1:0]  alloc_wat_vec;
  logic [INST_WIDTH-1:0] alloc_inst_arr [ISQ_DEPTH];
  logic [ISQ_DEPTH-1:0]  iss_clr_vec;

  logic [ISSUE_PORT-1:0] sel_val;
  logic [IDX_W-1:0]      sel_idx  [ISSUE_PORT];
  logic [INST_WIDTH-1:0] sel_inst [ISSUE_PORT];

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] alloc_num;
  logic [CNT_W-1:0] iss_num;
  logic             accept;

  // Readiness credit comes from the registered count only.
  assign isq_rdy = (cnt_reg <= CNT_W'(ISQ_DEPTH - INST_PORT));
  assign accept  = disp_en & isq_rdy & ~fls;
  assign rdy_vec = val_vec & ~wat_vec;
  assign isq_cnt = cnt_reg;

  generate
    for (genvar gi = 0; gi < ISQ_DEPTH; gi++) begin : g_ent
      logic [ENT_W-1:0] ent_w;

      isq_entry #(.INST_WIDTH(INST_WIDTH)) u_entry (
        .clk        (clk),
        .rst_n      (rst_n),
        .fls        (fls),
        .alloc      (alloc_vec[gi]),
        .alloc_wat  (alloc_wat_vec[gi]),
        .alloc_inst (alloc_inst_arr[gi]),
        .iss_clr    (iss_clr_vec[gi]),
        .wake       (clr_inst_wat[gi]),
        .ent        (ent_w)
      );

      assign val_vec[gi] = ent_w[ENT_VAL_BIT];
      assign wat_vec[gi] = ent_w[ENT_WAT_BIT];
      assign pld_arr[gi] = ent_w[ENT_PLD_LSB +: INST_WIDTH];
    end
  endgenerate

  // Port rank among valid ports is matched against slot rank among free slots;
  // ready rank below ISSUE_PORT picks the issue slot.
  always_comb begin
    logic [CNT_W-1:0] port_rank [INST_PORT];
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] fcnt;
    logic [CNT_W-1:0] rcnt;

    alloc_vec     = '0;
    alloc_wat_vec = '0;
    iss_clr_vec   = '0;
    sel_val       = '0;
    iss_num       = '0;
    pcnt          = '0;
    fcnt          = '0;
    rcnt          = '0;
    for (int s = 0; s < ISSUE_PORT; s++) begin
      sel_idx[s]  = '0;
      sel_inst[s] = '0;
    end
    for (int i = 0; i < ISQ_DEPTH; i++) alloc_inst_arr[i] = '0;

    for (int p = 0; p < INST_PORT; p++) begin
      port_rank[p] = pcnt;
      pcnt         = pcnt + CNT_W'(inst_val[p]);
    end
    alloc_num = accept ? pcnt : '0;

    for (int i = 0; i < ISQ_DEPTH; i++) begin
      if (!val_vec[i]) begin
        for (int p = 0; p < INST_PORT; p++) begin
          if (accept && inst_val[p] && (port_rank[p] == fcnt)) begin
            alloc_vec[i]      = 1'b1;
            alloc_wat_vec[i]  = inst_wat[p];
            alloc_inst_arr[i] = inst_in_flat[p*INST_WIDTH +: INST_WIDTH];
          end
        end
        fcnt = fcnt + CNT_W'(1);
      end
      if (rdy_vec[i]) begin
        for (int s = 0; s < ISSUE_PORT; s++) begin
          if (rcnt == CNT_W'(s)) begin
            sel_val[s]     = 1'b1;
            sel_idx[s]     = IDX_W'(i);
            sel_inst[s]    = pld_arr[i];
            iss_clr_vec[i] = 1'b1;
            iss_num        = iss_num + CNT_W'(1);
          end
        end
        rcnt = rcnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    cnt_next = cnt_reg + alloc_num - iss_num;
    if (fls) cnt_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_reg <= '0;
    else        cnt_reg <= cnt_next;
  end

  generate
    for (genvar gi = 0; gi < ISSUE_PORT; gi++) begin : g_iss
      logic             val_reg;
      logic [REC_W-1:0] rec_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          val_reg <= 1'b0;
          rec_reg <= '0;
        end else if (fls) begin
          val_reg <= 1'b0;
        end else begin
          val_reg <= sel_val[gi];
          rec_reg <= {ISQ_IDX_BITS_NUM'(sel_idx[gi]), sel_inst[gi]};
        end
      end

      assign iss_val[gi] = val_reg;
      assign iss_idx_flat[gi*ISQ_IDX_BITS_NUM +: ISQ_IDX_BITS_NUM] = rec_reg[INST_WIDTH +: ISQ_IDX_BITS_NUM];
      assign iss_inst_flat[gi*INST_WIDTH +: INST_WIDTH] = rec_reg[INST_WIDTH-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_isq_alloc.sv
// Self-checking bench for isq_alloc: directed scenarios plus randomized traffic
// compared against a slot-list reference model of the queue.
module tb_isq_alloc;

  localparam int DEPTH = 64;
  localparam int IDXW  = 6;
  localparam int NPORT = 4;
  localparam int NISS  = 2;
  localparam int IW    = 56;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   disp_en;
  logic [NPORT-1:0]       inst_val;
  logic [NPORT-1:0]       inst_wat;
  logic [IW*NPORT-1:0]    inst_in_flat;
  logic [DEPTH-1:0]       clr_inst_wat;
  logic                   fls;
  logic                   isq_rdy;
  logic [IDXW:0]          isq_cnt;
  logic [NISS-1:0]        iss_val;
  logic [IDXW*NISS-1:0]   iss_idx_flat;
  logic [IW*NISS-1:0]     iss_inst_flat;

  always #5 clk = ~clk;

  isq_alloc #(
    .ISQ_DEPTH(DEPTH), .ISQ_IDX_BITS_NUM(IDXW), .INST_PORT(NPORT),
    .ISSUE_PORT(NISS), .INST_WIDTH(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .disp_en(disp_en), .inst_val(inst_val),
    .inst_wat(inst_wat), .inst_in_flat(inst_in_flat), .clr_inst_wat(clr_inst_wat),
    .fls(fls), .isq_rdy(isq_rdy), .isq_cnt(isq_cnt), .iss_val(iss_val),
    .iss_idx_flat(iss_idx_flat), .iss_inst_flat(iss_inst_flat)
  );

  // Reference model: per-slot state plus the expected issue bus.
  bit              m_val [DEPTH];
  bit              m_wat [DEPTH];
  logic [IW-1:0]   m_pld [DEPTH];
  int              m_cnt;
  logic [NISS-1:0] e_iss_val;
  int              e_idx  [NISS];
  logic [IW-1:0]   e_inst [NISS];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int got_idx(input int s);
    return int'(iss_idx_flat[s*IDXW +: IDXW]);
  endfunction

  function automatic logic [IW-1:0] got_inst(input int s);
    return iss_inst_flat[s*IW +: IW];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_val[i] = 0; m_wat[i] = 0; m_pld[i] = '0;
    end
    m_cnt = 0;
    e_iss_val = '0;
  endfunction

  // Applies one clock edge's worth of queue behaviour to the model.
  function automatic void model_step();
    int free_q[$];
    int sel_q[$];
    int k;
    k = 0;
    if (fls) begin
      for (int i = 0; i < DEPTH; i++) m_val[i] = 0;
      m_cnt = 0;
      e_iss_val = '0;
      return;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (!m_val[i]) free_q.push_back(i);
      else if (!m_wat[i] && sel_q.size() < NISS) sel_q.push_back(i);
    end
    e_iss_val = '0;
    for (int s = 0; s < sel_q.size(); s++) begin
      e_iss_val[s] = 1'b1;
      e_idx[s]     = sel_q[s];
      e_inst[s]    = m_pld[sel_q[s]];
    end
    for (int i = 0; i < DEPTH; i++)
      if (clr_inst_wat[i] && m_val[i]) m_wat[i] = 0;
    foreach (sel_q[s]) m_val[sel_q[s]] = 0;
    if (disp_en && (DEPTH - m_cnt) >= NPORT) begin
      for (int p = 0; p < NPORT; p++) begin
        if (inst_val[p]) begin
          m_val[free_q[k]] = 1;
          m_wat[free_q[k]] = inst_wat[p];
          m_pld[free_q[k]] = inst_in_flat[p*IW +: IW];
          k++;
        end
      end
    end
    m_cnt = m_cnt + k - sel_q.size();
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [NPORT-1:0] v, input logic [NPORT-1:0] w, input int base);
    disp_en  = 1'b1;
    inst_val = v;
    inst_wat = w;
    for (int p = 0; p < NPORT; p++) inst_in_flat[p*IW +: IW] = IW'(base + p);
    $display("[TB] dispatch val=%b wat=%b base=0x%0h cnt_before=%0d", v, w, base, isq_cnt);
    tick();
    disp_en  = 1'b0;
    inst_val = '0;
    inst_wat = '0;
  endtask

  task automatic do_flush();
    fls = 1'b1;
    tick();
    fls = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; disp_en = 1'b0; inst_val = '0; inst_wat = '0;
    inst_in_flat = '0; clr_inst_wat = '0; fls = 1'b0;
    model_reset();
    #1;
    n_tests++; if (isq_cnt !== 7'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", isq_cnt); end
    n_tests++; if (isq_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got %b want 1", isq_rdy); end
    n_tests++; if (iss_val !== 2'b00) begin n_fail++; $display("FAIL reset_iss_val got %b want 00", iss_val); end
    n_tests++; if (iss_idx_flat !== '0 || iss_inst_flat !== '0) begin
      n_fail++; $display("FAIL reset_iss_bus got idx=%h inst=%h want 0", iss_idx_flat, iss_inst_flat);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    $display("[TB] reset released cnt=%0d rdy=%b", isq_cnt, isq_rdy);
  endtask

  task automatic test_basic();
    dispatch(4'b1111, 4'b0000, 'hA);
    n_tests++; if (isq_cnt !== 7'd4) begin n_fail++; $display("FAIL basic_cnt4 got %0d want 4", isq_cnt); end
    n_tests++; if (iss_val !== 2'b00) begin n_fail++; $display("FAIL basic_noiss got %b want 00", iss_val); end
    tick();
    n_tests++; if (iss_val !== 2'b11 || got_idx(0) != 0 || got_idx(1) != 1) begin
      n_fail++; $display("FAIL basic_iss01 got val=%b idx=%0d,%0d want 11 idx=0,1", iss_val, got_idx(0), got_idx(1));
    end
    n_tests++; if (got_inst(0) !== IW'('hA) || got_inst(1) !== IW'('hB)) begin
      n_fail++; $display("FAIL basic_inst01 got %h,%h want a,b", got_inst(0), got_inst(1));
    end
    tick();
    n_tests++; if (iss_val !== 2'b11 || got_idx(0) != 2 || got_idx(1) != 3 || got_inst(1) !== IW'('hD)) begin
      n_fail++; $display("FAIL basic_iss23 got val=%b idx=%0d,%0d inst1=%h want 11 idx=2,3 inst1=d",
                         iss_val, got_idx(0), got_idx(1), got_inst(1));
    end
    n_tests++; if (isq_cnt !== 7'd0) begin n_fail++; $display("FAIL basic_cnt0 got %0d want 0", isq_cnt); end
    tick();
  endtask

  task automatic test_sparse();
    dispatch(4'b1010, 4'b0000, 'h10);
    n_tests++; if (isq_cnt !== 7'd2) begin n_fail++; $display("FAIL sparse_cnt got %0d want 2", isq_cnt); end
    tick();
    n_tests++; if (iss_val !== 2'b11 || got_idx(0) != 0 || got_idx(1) != 1 ||
                   got_inst(0) !== IW'('h11) || got_inst(1) !== IW'('h13)) begin
      n_fail++; $display("FAIL sparse_iss got val=%b idx=%0d,%0d inst=%h,%h want 11 idx=0,1 inst=11,13",
                         iss_val, got_idx(0), got_idx(1), got_inst(0), got_inst(1));
    end
    tick();
  endtask

  task automatic test_full();
    for (int g = 0; g < 15; g++) dispatch(4'b1111, 4'b1111, 4*g);
    dispatch(4'b0001, 4'b0001, 60);
    n_tests++; if (isq_cnt !== 7'd61 || isq_rdy !== 1'b0) begin
      n_fail++; $display("FAIL full_61 got cnt=%0d rdy=%b want 61 0", isq_cnt, isq_rdy);
    end
    dispatch(4'b1111, 4'b0000, 'h99);
    n_tests++; if (isq_cnt !== 7'd61) begin n_fail++; $display("FAIL full_drop got %0d want 61", isq_cnt); end
    clr_inst_wat = '0;
    clr_inst_wat[5] = 1'b1;
    tick();
    clr_inst_wat = '0;
    n_tests++; if (iss_val !== 2'b00) begin n_fail++; $display("FAIL full_wake_early got %b want 00", iss_val); end
    tick();
    n_tests++; if (iss_val !== 2'b01 || got_idx(0) != 5 || got_inst(0) !== IW'(5)) begin
      n_fail++; $display("FAIL full_wake_iss got val=%b idx=%0d inst=%h want 01 5 5", iss_val, got_idx(0), got_inst(0));
    end
    n_tests++; if (isq_cnt !== 7'd60 || isq_rdy !== 1'b1) begin
      n_fail++; $display("FAIL full_60 got cnt=%0d rdy=%b want 60 1", isq_cnt, isq_rdy);
    end
    do_flush();
    n_tests++; if (isq_cnt !== 7'd0) begin n_fail++; $display("FAIL full_flush got %0d want 0", isq_cnt); end
  endtask

  task automatic test_priority();
    dispatch(4'b1111, 4'b1111, 0);
    dispatch(4'b1111, 4'b1111, 4);
    dispatch(4'b0011, 4'b0001, 8);
    tick();
    n_tests++; if (iss_val !== 2'b01 || got_idx(0) != 9) begin
      n_fail++; $display("FAIL prio_9 got val=%b idx=%0d want 01 9", iss_val, got_idx(0));
    end
    clr_inst_wat = '0;
    clr_inst_wat[7] = 1'b1;
    tick();
    clr_inst_wat = '0;
    tick();
    n_tests++; if (iss_val !== 2'b01 || got_idx(0) != 7 || got_inst(0) !== IW'(7)) begin
      n_fail++; $display("FAIL prio_7 got val=%b idx=%0d inst=%h want 01 7 7", iss_val, got_idx(0), got_inst(0));
    end
    do_flush();
  endtask

  task automatic test_flush();
    dispatch(4'b1111, 4'b1111, 'h30);
    dispatch(4'b1111, 4'b0000, 'h20);
    fls = 1'b1; disp_en = 1'b1; inst_val = 4'b1111; clr_inst_wat = '1;
    tick();
    fls = 1'b0; disp_en = 1'b0; inst_val = '0;
    n_tests++; if (isq_cnt !== 7'd0 || iss_val !== 2'b00 || isq_rdy !== 1'b1) begin
      n_fail++; $display("FAIL flush_now got cnt=%0d val=%b rdy=%b want 0 00 1", isq_cnt, iss_val, isq_rdy);
    end
    tick();
    clr_inst_wat = '0;
    tick();
    n_tests++; if (iss_val !== 2'b00 || isq_cnt !== 7'd0) begin
      n_fail++; $display("FAIL flush_empty got val=%b cnt=%0d want 00 0", iss_val, isq_cnt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      disp_en  = ($urandom_range(0, 3) != 0);
      inst_val = NPORT'($urandom());
      inst_wat = NPORT'($urandom()) | NPORT'($urandom());
      for (int p = 0; p < NPORT; p++) inst_in_flat[p*IW +: IW] = IW'({$urandom(), $urandom()});
      for (int i = 0; i < DEPTH; i++) clr_inst_wat[i] = ($urandom_range(0, 9) == 0);
      fls = ($urandom_range(0, 59) == 0);
      tick();
      if (iss_val != 0)
        $display("[TB] cyc %0d issue val=%b idx=%0d,%0d cnt=%0d", c, iss_val, got_idx(0), got_idx(1), isq_cnt);
      n_tests++; if (isq_cnt !== 7'(m_cnt)) begin
        n_fail++; $display("FAIL rand_cnt cyc %0d got %0d want %0d", c, isq_cnt, m_cnt);
      end
      n_tests++; if (isq_rdy !== ((DEPTH - m_cnt) >= NPORT)) begin
        n_fail++; $display("FAIL rand_rdy cyc %0d got %b want %b", c, isq_rdy, (DEPTH - m_cnt) >= NPORT);
      end
      n_tests++; if (iss_val !== e_iss_val) begin
        n_fail++; $display("FAIL rand_iss_val cyc %0d got %b want %b", c, iss_val, e_iss_val);
      end
      for (int s = 0; s < NISS; s++) begin
        if (e_iss_val[s]) begin
          n_tests++; if (got_idx(s) != e_idx[s] || got_inst(s) !== e_inst[s]) begin
            n_fail++; $display("FAIL rand_slot%0d cyc %0d got idx=%0d inst=%h want idx=%0d inst=%h",
                               s, c, got_idx(s), got_inst(s), e_idx[s], e_inst[s]);
          end
        end
      end
    end
    disp_en = 1'b0; inst_val = '0; inst_wat = '0; clr_inst_wat = '0; fls = 1'b0;
    do_flush();
  endtask

  task automatic test_async_reset();
    for (int g = 0; g < 4; g++) dispatch(4'b1111, 4'b1111, 'h40 + 4*g);
    clr_inst_wat = '0;
    clr_inst_wat[0] = 1'b1;
    clr_inst_wat[1] = 1'b1;
    dispatch(4'b1111, 4'b1111, 'h50);
    clr_inst_wat = '0;
    dispatch(4'b0011, 4'b0011, 'h60);
    n_tests++; if (isq_cnt !== 7'd20 || iss_val !== 2'b11 || got_idx(1) != 1) begin
      n_fail++; $display("FAIL arst_pre got cnt=%0d val=%b idx1=%0d want 20 11 1", isq_cnt, iss_val, got_idx(1));
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (isq_cnt !== 7'd0 || isq_rdy !== 1'b1) begin
      n_fail++; $display("FAIL arst_cnt got cnt=%0d rdy=%b want 0 1", isq_cnt, isq_rdy);
    end
    n_tests++; if (iss_val !== 2'b00 || iss_idx_flat !== '0 || iss_inst_flat !== '0) begin
      n_fail++; $display("FAIL arst_iss got val=%b idx=%h inst=%h want 0", iss_val, iss_idx_flat, iss_inst_flat);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clr_inst_wat = '1;
    tick();
    clr_inst_wat = '0;
    tick();
    n_tests++; if (iss_val !== 2'b00 || isq_cnt !== 7'd0) begin
      n_fail++; $display("FAIL arst_empty got val=%b cnt=%0d want 00 0", iss_val, isq_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sparse();
    test_full();
    test_priority();
    test_flush();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
